// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_e;

    localparam logic [2:0] IFETCH_FUNCT3 = 3'b010;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
        logic        wen;
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and shared memory bus of the arbiter.
interface mem_arbiter_if;

    logic        IReq_i;
    logic [31:0] IAddr_i;
    logic [31:0] IReadD_o;
    logic        IReady_o;

    logic        DRead_i;
    logic        DWrite_i;
    logic [31:0] DAddr_i;
    logic [31:0] DWriteD_i;
    logic [2:0]  Dfunct3_i;
    logic [31:0] DReadD_o;
    logic        DReady_o;

    logic [31:0] MAddr_o;
    logic [31:0] MWriteD_o;
    logic        Mread_o;
    logic        Mwrite_o;
    logic [2:0]  Mfunct3_o;
    logic [31:0] MReadD_i;
    logic        Mready_i;

    modport master (
        input  IReq_i, IAddr_i,
        output IReadD_o, IReady_o,
        input  DRead_i, DWrite_i, DAddr_i, DWriteD_i, Dfunct3_i,
        output DReadD_o, DReady_o,
        output MAddr_o, MWriteD_o, Mread_o, Mwrite_o, Mfunct3_o,
        input  MReadD_i, Mready_i
    );

    modport slave (
        output IReq_i, IAddr_i,
        input  IReadD_o, IReady_o,
        output DRead_i, DWrite_i, DAddr_i, DWriteD_i, Dfunct3_i,
        input  DReadD_o, DReady_o,
        input  MAddr_o, MWriteD_o, Mread_o, Mwrite_o, Mfunct3_o,
        output MReadD_i, Mready_i
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Two-way round-robin choice: on a tie the port not granted last wins.
module rr_picker (
    input  logic ireq,
    input  logic dreq,
    input  logic last_d,
    output logic igrant,
    output logic dgrant
);

    always_comb begin
        igrant = 1'b0;
        dgrant = 1'b0;
        unique case (1'b1)
            (ireq && dreq): begin
                igrant = last_d;
                dgrant = !last_d;
            end
            (dreq && !ireq): dgrant = 1'b1;
            (ireq && !dreq): igrant = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and data load/store;
// the memory side is driven only from the request latched at grant.
module mem_arbiter
    import mem_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.master bus
);

    arb_state_e state;
    arb_state_e state_nx;
    arb_req_t   req_q;
    arb_req_t   req_nx;
    logic       last_d;
    logic       ireq;
    logic       dreq;
    logic       igrant;
    logic       dgrant;
    logic       grant;
    logic       done;

    // A port in its Ready cycle is masked so a held request is not re-served.
    assign ireq  = bus.IReq_i && !bus.IReady_o;
    assign dreq  = (bus.DRead_i || bus.DWrite_i) && !bus.DReady_o;
    assign grant = (state == IDLE) && (igrant || dgrant);
    assign done  = (state != IDLE) && bus.Mready_i;

    rr_picker u_rr (
        .ireq   (ireq),
        .dreq   (dreq),
        .last_d (last_d),
        .igrant (igrant),
        .dgrant (dgrant)
    );

    always_comb begin
        req_nx = '{addr: bus.IAddr_i, wdata: '0,
                   funct3: IFETCH_FUNCT3, wen: 1'b0};
        if (dgrant) begin
            req_nx = '{addr: bus.DAddr_i, wdata: bus.DWriteD_i,
                       funct3: bus.Dfunct3_i, wen: bus.DWrite_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (dgrant)      state_nx = SERVE_D;
                else if (igrant) state_nx = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (bus.Mready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.Mread_o  = 1'b0;
        bus.Mwrite_o = 1'b0;
        if (state != IDLE) begin
            bus.Mread_o  = !req_q.wen;
            bus.Mwrite_o = req_q.wen;
        end
    end

    assign bus.MAddr_o   = req_q.addr;
    assign bus.MWriteD_o = req_q.wdata;
    assign bus.Mfunct3_o = req_q.funct3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q        <= '0;
            last_d       <= 1'b0;
            bus.IReady_o <= 1'b0;
            bus.DReady_o <= 1'b0;
            bus.IReadD_o <= '0;
            bus.DReadD_o <= '0;
        end else begin
            bus.IReady_o <= done && (state == SERVE_I);
            bus.DReady_o <= done && (state == SERVE_D);
            if (grant) begin
                req_q  <= req_nx;
                last_d <= dgrant;
            end
            if (done && (state == SERVE_I)) begin
                bus.IReadD_o <= bus.MReadD_i;
            end
            if (done && (state == SERVE_D) && !req_q.wen) begin
                bus.DReadD_o <= bus.MReadD_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Random fetch/load/store traffic against a transaction-level model of the
// arbiter; a negedge monitor scores grants, bus attributes and responses.
module tb_mem_arbiter;
    import mem_pkg::*;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
    } dop_t;

    logic clk = 1'b0;
    logic rst_n;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit stop = 0;
    bit slow = 0;

    logic [31:0] iq[$];
    dop_t        dq[$];
    logic [31:0] cur_i = '0;
    dop_t        cur_d = '0;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not seen within bound at %0t", name, $time);
    endtask

    task automatic drive_d(input dop_t op);
        bus.DWrite_i  = op.wr;
        bus.DRead_i   = op.rd;
        bus.DAddr_i   = op.addr;
        bus.DWriteD_i = op.wdata;
        bus.Dfunct3_i = op.f3;
    endtask

    initial begin : i_drv
        bus.IReq_i  = 1'b0;
        bus.IAddr_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) continue;
            if (bus.IReq_i) begin
                if (!bus.IReady_o) continue;
                bus.IReq_i = 1'b0;
            end
            if (!stop && $urandom_range(0, 2) != 0) begin
                cur_i       = $urandom & 32'h7FFF_FFFC;
                bus.IAddr_i = cur_i;
                bus.IReq_i  = 1'b1;
                iq.push_back(cur_i);
            end
        end
    end

    initial begin : d_drv
        dop_t op;
        drive_d('0);
        forever begin
            @(posedge clk);
            #1;
            if (bus.DRead_i || bus.DWrite_i) begin
                if (!rst_n) begin
                    drive_d(cur_d);
                    continue;
                end
                if (!bus.DReady_o) begin
                    if ((bus.Mread_o || bus.Mwrite_o) && bus.MAddr_o[31]
                        && $urandom_range(0, 1) == 1) begin
                        bus.DAddr_i   = $urandom;
                        bus.DWriteD_i = $urandom;
                        bus.Dfunct3_i = 3'($urandom);
                    end
                    continue;
                end
                bus.DRead_i  = 1'b0;
                bus.DWrite_i = 1'b0;
            end
            if (rst_n && !stop && $urandom_range(0, 2) != 0) begin
                op.wr    = 1'($urandom);
                op.rd    = op.wr ? 1'($urandom) : 1'b1;
                op.addr  = $urandom | 32'h8000_0000;
                op.wdata = $urandom;
                op.f3    = 3'($urandom);
                cur_d    = op;
                drive_d(op);
                dq.push_back(op);
            end
        end
    end

    initial begin : mem_drv
        bus.Mready_i = 1'b0;
        bus.MReadD_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (slow) bus.Mready_i = rst_n && ($urandom_range(0, 6) == 0);
            else      bus.Mready_i = rst_n && ($urandom_range(0, 1) == 1);
            bus.MReadD_i = bus.Mread_o ? mem_data(bus.MAddr_o) : $urandom;
        end
    end

    initial begin : monitor
        bit exp_ir = 0, exp_dr = 0, last_d = 0;
        bit prev_ok = 0, prev_idle = 1, wi = 0, wd = 0;
        bit s, port = 0, want;
        logic [31:0] pi = '0, i_out = '0, d_out = '0;
        dop_t pd = '0, dop;
        logic [31:0] s_addr = '0, s_wd = '0;
        logic [2:0]  s_f3 = '0;
        logic        s_rd = 0, s_wr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_ir = 0; exp_dr = 0; last_d = 0; prev_ok = 0;
                i_out = '0; d_out = '0;
                continue;
            end
            chk("i_ready", 32'(bus.IReady_o), 32'(exp_ir));
            chk("d_ready", 32'(bus.DReady_o), 32'(exp_dr));
            if (exp_ir) begin
                if (iq.size() == 0) fail("i_queue");
                else i_out = mem_data(iq.pop_front());
            end
            if (exp_dr) begin
                if (dq.size() == 0) fail("d_queue");
                else begin
                    dop = dq.pop_front();
                    if (!dop.wr) d_out = mem_data(dop.addr);
                end
            end
            chk("i_rdata", bus.IReadD_o, i_out);
            chk("d_rdata", bus.DReadD_o, d_out);
            s = bus.Mread_o || bus.Mwrite_o;
            chk("strobe_excl", 32'(bus.Mread_o & bus.Mwrite_o), 32'd0);
            if (s) port = bus.MAddr_o[31];
            if (prev_ok && prev_idle) begin
                chk("grant", 32'(s), 32'(wi || wd));
                if (s) begin
                    want = (wi && wd) ? !last_d : wd;
                    chk("grant_port", 32'(port), 32'(want));
                    last_d = port;
                    if (!port) begin
                        chk("i_addr", bus.MAddr_o, pi);
                        chk("i_f3", 32'(bus.Mfunct3_o), 32'(IFETCH_FUNCT3));
                        chk("i_wr", 32'(bus.Mwrite_o), 32'd0);
                        chk("i_wd", bus.MWriteD_o, 32'd0);
                    end else begin
                        chk("d_addr", bus.MAddr_o, pd.addr);
                        chk("d_f3", 32'(bus.Mfunct3_o), 32'(pd.f3));
                        chk("d_wr", 32'(bus.Mwrite_o), 32'(pd.wr));
                        chk("d_rd", 32'(bus.Mread_o), 32'(!pd.wr));
                        if (pd.wr) chk("d_wd", bus.MWriteD_o, pd.wdata);
                    end
                end
            end else if (prev_ok) begin
                chk("busy", 32'(s), 32'(!(exp_ir || exp_dr)));
                if (s) begin
                    chk("hold_addr", bus.MAddr_o, s_addr);
                    chk("hold_f3", 32'(bus.Mfunct3_o), 32'(s_f3));
                    chk("hold_rd", 32'(bus.Mread_o), 32'(s_rd));
                    chk("hold_wr", 32'(bus.Mwrite_o), 32'(s_wr));
                    chk("hold_wd", bus.MWriteD_o, s_wd);
                end
            end
            wi = bus.IReq_i && !exp_ir;
            wd = (bus.DRead_i || bus.DWrite_i) && !exp_dr;
            pi = cur_i;
            pd = cur_d;
            exp_ir = s && bus.Mready_i && !port;
            exp_dr = s && bus.Mready_i && port;
            prev_idle = !s;
            prev_ok = 1;
            if (s) begin
                s_addr = bus.MAddr_o;
                s_f3   = bus.Mfunct3_o;
                s_rd   = bus.Mread_o;
                s_wr   = bus.Mwrite_o;
                s_wd   = bus.MWriteD_o;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_iready"}, 32'(bus.IReady_o), 32'd0);
        chk({tag, "_dready"}, 32'(bus.DReady_o), 32'd0);
        chk({tag, "_irdata"}, bus.IReadD_o, 32'd0);
        chk({tag, "_drdata"}, bus.DReadD_o, 32'd0);
        chk({tag, "_maddr"}, bus.MAddr_o, 32'd0);
        chk({tag, "_mwd"}, bus.MWriteD_o, 32'd0);
        chk({tag, "_mf3"}, 32'(bus.Mfunct3_o), 32'd0);
        chk({tag, "_mread"}, 32'(bus.Mread_o), 32'd0);
        chk({tag, "_mwrite"}, 32'(bus.Mwrite_o), 32'd0);
    endtask

    initial begin : main
        bit found;
        bit done;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        repeat (1500) @(posedge clk);
        slow = 1;
        repeat (600) @(posedge clk);
        slow = 0;

        for (int r = 0; r < 3; r++) begin
            found = 0;
            for (int k = 0; k < 400 && !found; k++) begin
                @(negedge clk);
                if ((bus.Mread_o || bus.Mwrite_o) && bus.MAddr_o[31]) found = 1;
            end
            if (!found) fail("serve_d_wait");
            else begin
                #2 rst_n = 1'b0;
                #1 chk_all_zero("async_reset");
                repeat (3) @(posedge clk);
                #3 rst_n = 1'b1;
            end
            repeat (300) @(posedge clk);
        end

        repeat (1200) @(posedge clk);
        stop = 1;
        done = 0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(posedge clk);
            done = (iq.size() == 0) && (dq.size() == 0);
        end
        if (!done) fail("drain");
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 IReq_i  in  1  instruction-fetch read request; held until IReady_o.
REQ-004 IAddr_i  in  32  fetch address.
REQ-005 IReadD_o  out  32  fetched word.
REQ-006 IReady_o  out  1  one-cycle completion pulse, fetch port.
REQ-007 DRead_i  in  1  data read request; held until DReady_o.
REQ-008 DWrite_i  in  1  data write request; held until DReady_o.
REQ-009 DAddr_i  in  32  data address.
REQ-010 DWriteD_i  in  32  store data.
REQ-011 Dfunct3_i  in  3  load/store width and sign code.
REQ-012 DReadD_o  out  32  load result.
REQ-013 DReady_o  out  1  one-cycle completion pulse, data port.
REQ-014 MAddr_o, MWriteD_o  out  32 each  shared memory address and store data.
REQ-015 Mread_o, Mwrite_o  out  1 each  shared memory read and write strobes.
REQ-016 Mfunct3_o  out  3  shared memory width code.
REQ-017 MReadD_i  in  32  shared memory read data.
REQ-018 Mready_i  in  1  shared memory completion.

Function
REQ-019 The FSM SHALL have states IDLE, SERVE_I and SERVE_D.
REQ-020 IDLE SHALL drive Mread_o and Mwrite_o at 0 and ignore Mready_i.
REQ-021 A D request SHALL be DRead_i or DWrite_i; when both are high, it SHALL be a write with Mread_o held at 0.
REQ-022 In IDLE, a single pending request SHALL be granted on the next edge.
REQ-023 With I and D both pending, the port not granted last SHALL win; after reset, D wins.
REQ-024 At grant, address, store data, funct3 and direction SHALL be latched; M* outputs SHALL come only from these latches, stable for the whole transaction.
REQ-025 A fetch SHALL drive Mfunct3_o = IFETCH_FUNCT3 (3'b010), Mwrite_o = 0 and MWriteD_o = 0.
REQ-026 In SERVE_x, the edge with Mready_i = 1 SHALL return the FSM to IDLE and pulse the matching Ready_o high for exactly the next cycle.
REQ-027 On a read, that same edge SHALL capture MReadD_i into IReadD_o or DReadD_o.
REQ-028 On a write, DReadD_o SHALL hold its previous value.
REQ-029 Minimum latency: grant edge, then 1 cycle Mread_o/Mwrite_o high when Mready_i arrives that cycle, then Ready_o; total 2 cycles plus memory wait.
REQ-030 In the cycle a port's Ready_o is high, that port's request SHALL be masked from arbitration so a held request is not re-granted.
REQ-031 The other port SHALL be grantable in that same IDLE cycle.
REQ-032 Requests changing attributes mid-transaction SHALL have no effect on the M* outputs.
REQ-033 Mready_i held high over several cycles SHALL complete only the current transaction.

Reset
REQ-034 Reset SHALL force IDLE, last-grant = I so that D wins next, and all outputs to 0, abandoning any in-flight transaction with no Ready_o pulse.
REQ-035 Release of reset SHALL cause no memory strobe before a new grant.

Structure
REQ-036 The following SHALL live in mem_pkg:
- arb_state_e (IDLE, SERVE_I, SERVE_D);
- IFETCH_FUNCT3;
- the arb_req_t struct (addr, wdata, funct3, wen).
REQ-037 The round-robin choice SHALL be a combinational sub-module rr_picker (2 requests, last-grant in, grant out); everything else SHALL stay in mem_arbiter.

Verification
REQ-038 Scenario: fetch only, IAddr_i = 0x100, Mready_i one cycle after grant with MReadD_i = 0xDEADBEEF -> Mread_o 1 cycle, Mfunct3_o = 010, IReadD_o = 0xDEADBEEF, IReady_o single pulse 2 cycles after request.
REQ-039 Scenario: I and D (read 0x200) together from reset -> D served first, I granted in the IDLE cycle of DReady_o, next tie goes to D again only after I is served.
REQ-040 Scenario: D write 0x300 with data 0x55 and Dfunct3_i = 000 while DRead_i is also high -> Mwrite_o = 1, Mread_o = 0, MWriteD_o = 0x55, DReadD_o unchanged, DReady_o pulse.
REQ-041 Scenario: memory stalls 5 cycles while DAddr_i changes -> MAddr_o constant until Mready_i, exactly one DReady_o.
REQ-042 Scenario: rst_n low during SERVE_D -> all outputs 0 immediately, no DReady_o; after release, a held request is granted with D priority.
REQ-043 Scenario: requester keeps IReq_i high through the IReady_o cycle -> that cycle causes no re-grant; the held request is granted one cycle later.
